transciever_serial_transmitter: RTL and testbench
=================================================

Name: transciever_serial_transmitter

Overview:
- Serial output stage directly downstream of the transceiver bus interface and its transmit FIFO.
- Drains the transmit FIFO when software writes the start bit, one byte per frame.
- Each byte goes out as an 8N1 frame: 1 start bit, 8 data bits sent LSB first, 1 stop bit. Every bit lasts bit_time clocks.
- Drives the physical TX line, honours line_invert, and reports transmission_in_progress back to the bus interface status register.

Parameters:
- DATA_BITS, 8, data bits per frame.
- BIT_TIME_WIDTH, 32, width of the bit_time input and the internal bit counter.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset: asynchronous, active-low; clock: clk
- bit_time  input  BIT_TIME_WIDTH  clocks per bit, from the bus interface bit time register
- start_transmission  input  1  one-cycle pulse from the bus interface (CSR write with data[5]=1)
- line_invert  input  1  invert the TX line polarity
- fifo_data  input  DATA_BITS  head of the transmit FIFO; first-word-fall-through, valid while fifo_has_data=1
- fifo_has_data  input  1  transmit FIFO is non-empty
- fifo_read  output  1  one-cycle pop strobe to the transmit FIFO
- tx_line  output  1  registered serial line output
- transmission_in_progress  output  1  high from the first start bit until the last stop bit ends
- bit_tick  output  1  one-cycle pulse at each bit boundary; feeds the sound/loop logic

Behaviour:
- Reset values:
  - State IDLE; fifo_read=0; bit_tick=0; transmission_in_progress=0.
  - tx_line=1 (idle mark, reset uses line_invert=0); shift register=0; bit counter=0; bit index=0.
- States: IDLE, START, DATA, STOP.
- Frame launch: in IDLE, start_transmission=1 with fifo_has_data=1 at edge N:
  - fifo_read is asserted combinationally in the cycle before edge N.
  - fifo_data is captured into the shift register at edge N.
  - bit_time is latched into bit_time_q at edge N.
  - State becomes START and transmission_in_progress rises at edge N.
  - tx_line carries the start level from edge N+1 (one register stage).
- Empty FIFO: start_transmission with fifo_has_data=0 is ignored. State stays IDLE, no fifo_read, in_progress stays low.
- Busy: start_transmission outside IDLE is ignored.
- Bit timing:
  - The counter loads bit_time_q-1 on entering each bit and decrements to 0.
  - At 0, bit_tick pulses and the next bit begins.
  - bit_time of 0 or 1 is treated as 1 clock per bit.
  - bit_time changes take effect only at the next frame launch.
- START: line level 0. After one bit time, go to DATA with bit index 0.
- DATA:
  - Line level = shift register LSB; the register shifts right at each bit boundary.
  - After DATA_BITS bits, go to STOP.
- STOP: line level 1. At the end of the bit:
  - If fifo_has_data=1: assert fifo_read in that cycle, capture the new byte, go to START. Frames are back-to-back with no idle gap.
  - Otherwise go to IDLE and deassert transmission_in_progress at the same edge.
- A frame lasts exactly (2+DATA_BITS)*max(bit_time_q,1) clocks.
- tx_line is registered as line_level XOR line_invert.
  - line_invert is not latched, so it applies from the next clock, even mid-frame.
  - In IDLE, tx_line = 1 XOR line_invert.
- fifo_read is never asserted when fifo_has_data=0. It pulses at most once per frame.
- Reset mid-frame aborts immediately: tx_line returns to 1, and the byte already popped is lost.

Decomposition:
- Shared package transciever_pkg holds:
  - the state enum;
  - FRAME_BITS = DATA_BITS+2;
  - START_LEVEL=0, STOP_LEVEL=1, IDLE_LEVEL=1.
- One sub-module, transciever_bit_timer: a down-counter with load, bit_time_q latch, minimum-1 clamp and bit_tick generation. The receiver reuses it.

Test Plan:
- bit_time=4, FIFO holds 0xA5, pulse start → fifo_read one cycle; tx_line sequence 0,1,0,1,0,0,1,0,1,1, each held 4 clocks; in_progress high exactly 40 clocks.
- FIFO holds 0x00 and 0xFF, bit_time=3 → two frames with no gap between stop and next start; two fifo_read pulses 30 clocks apart; in_progress high 60 clocks.
- Empty FIFO, start pulse → no fifo_read, tx_line stays 1, in_progress stays 0.
- line_invert=1 idle → tx_line=0; send 0x01 with bit_time=2 → line 1,0,1,1,1,1,1,1,1,0. Toggle invert mid-frame → polarity flips on the next clock.
- bit_time=0 and 1 → 1-clock bits, 10-clock frame. bit_time written 4→8 mid-frame → current frame stays at 4, next frame uses 8.
- rst_n asserted during DATA bit 3 → tx_line=1, in_progress=0, fifo_read=0 asynchronously. Start after reset sends the next FIFO byte correctly.

Source files
------------

// File: rtl/transciever_pkg.sv
// Shared types and line levels for the transceiver serial datapath.
// Pure declarations: no logic, no latency, no flow control.
package transciever_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int TX_DATA_BITS = 8;
  localparam int FRAME_BITS   = TX_DATA_BITS + 2;

  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/transciever_serial_transmitter_if.sv
// Bus-interface/FIFO side of the serial transmitter: control, FIFO head and line status.
// Wires only; fifo_read is the sole flow-control strobe (pop when asserted).
interface transciever_serial_transmitter_if #(
  parameter int DATA_BITS      = 8,
  parameter int BIT_TIME_WIDTH = 32
);
  logic [BIT_TIME_WIDTH-1:0] bit_time;
  logic                      start_transmission;
  logic                      line_invert;
  logic [DATA_BITS-1:0]      fifo_data;
  logic                      fifo_has_data;
  logic                      fifo_read;
  logic                      tx_line;
  logic                      transmission_in_progress;
  logic                      bit_tick;

  modport master (
    output bit_time, start_transmission, line_invert, fifo_data, fifo_has_data,
    input  fifo_read, tx_line, transmission_in_progress, bit_tick
  );

  modport slave (
    input  bit_time, start_transmission, line_invert, fifo_data, fifo_has_data,
    output fifo_read, tx_line, transmission_in_progress, bit_tick
  );
endinterface

// File: rtl/transciever_bit_timer.sv
// Bit-period down-counter: latches bit_time on launch, expires after max(bit_time,1) clocks per bit.
// expire is combinational on the last clock of a bit; bit_tick is the registered copy; no backpressure.
module transciever_bit_timer #(
  parameter int BIT_TIME_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [BIT_TIME_WIDTH-1:0] bit_time,
  input  logic                      launch,
  input  logic                      reload,
  input  logic                      enable,
  output logic                      expire,
  output logic                      bit_tick
);
  localparam logic [BIT_TIME_WIDTH-1:0] ONE = BIT_TIME_WIDTH'(1);

  logic [BIT_TIME_WIDTH-1:0] bit_time_q;
  logic [BIT_TIME_WIDTH-1:0] cnt;
  logic [BIT_TIME_WIDTH-1:0] in_clamped;
  logic [BIT_TIME_WIDTH-1:0] q_clamped;

  // Zero would underflow the counter, so it behaves like one clock per bit.
  assign in_clamped = (bit_time   == '0) ? ONE : bit_time;
  assign q_clamped  = (bit_time_q == '0) ? ONE : bit_time_q;
  assign expire     = enable && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_time_q <= '0;
      cnt        <= '0;
      bit_tick   <= 1'b0;
    end else begin
      bit_tick <= expire;
      if (launch) begin
        bit_time_q <= bit_time;
        cnt        <= in_clamped - ONE;
      end else if (reload) begin
        cnt <= q_clamped - ONE;
      end else if (cnt != '0) begin
        cnt <= cnt - ONE;
      end
    end
  end
endmodule

// File: rtl/transciever_serial_transmitter.sv
// 8N1 serial transmitter draining a FWFT FIFO; tx_line lags the state register by one clock.
// Pops one byte per frame only when the FIFO is non-empty; starts while busy are ignored.
module transciever_serial_transmitter
  import transciever_pkg::*;
#(
  parameter int DATA_BITS      = 8,
  parameter int BIT_TIME_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  transciever_serial_transmitter_if.slave bus
);
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  tx_state_t            state;
  logic [DATA_BITS-1:0] shreg;
  logic [IDX_W-1:0]     bit_idx;
  logic                 tx_line_q;
  logic                 in_prog_q;
  logic                 line_level;
  logic                 expire;
  logic                 tick;
  logic                 launch;

  // A stop bit that ends with data waiting launches the next frame with no idle gap.
  assign launch = bus.fifo_has_data &&
                  (((state == IDLE) && bus.start_transmission) ||
                   ((state == STOP) && expire));

  assign bus.fifo_read                = launch;
  assign bus.tx_line                  = tx_line_q;
  assign bus.transmission_in_progress = in_prog_q;
  assign bus.bit_tick                 = tick;

  transciever_bit_timer #(
    .BIT_TIME_WIDTH(BIT_TIME_WIDTH)
  ) u_bit_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .bit_time (bus.bit_time),
    .launch   (launch),
    .reload   (expire && !launch),
    .enable   (state != IDLE),
    .expire   (expire),
    .bit_tick (tick)
  );

  always_comb begin
    line_level = IDLE_LEVEL;
    case (state)
      START:   line_level = START_LEVEL;
      DATA:    line_level = shreg[0];
      STOP:    line_level = STOP_LEVEL;
      default: line_level = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_idx   <= '0;
      tx_line_q <= IDLE_LEVEL;
      in_prog_q <= 1'b0;
    end else begin
      // Polarity is applied at the output register so an invert change lands on the next clock.
      tx_line_q <= line_level ^ bus.line_invert;
      case (state)
        IDLE: begin
          if (launch) begin
            shreg     <= bus.fifo_data;
            state     <= START;
            in_prog_q <= 1'b1;
          end
        end
        START: begin
          if (expire) begin
            state   <= DATA;
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (expire) begin
            shreg <= shreg >> 1;
            if (bit_idx == LAST_IDX) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        STOP: begin
          if (expire) begin
            if (launch) begin
              shreg <= bus.fifo_data;
              state <= START;
            end else begin
              state     <= IDLE;
              in_prog_q <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_transciever_serial_transmitter.sv
// Directed bench for the serial transmitter: vector table of single frames plus corner sequences.
module tb_transciever_serial_transmitter;

  logic clk = 1'b0;
  logic rst_n;

  transciever_serial_transmitter_if #(.DATA_BITS(8), .BIT_TIME_WIDTH(32)) bus ();

  transciever_serial_transmitter #(.DATA_BITS(8), .BIT_TIME_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // FIFO model: first-word-fall-through, popped on the edge where fifo_read is high.
  logic [7:0] fmem [0:31];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pop_cnt = 0;
  int bad_pops = 0;
  int cyc = 0;
  int pop_cyc [0:31];

  assign bus.fifo_data     = fmem[rd_ptr[4:0]];
  assign bus.fifo_has_data = (rd_ptr != wr_ptr);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.fifo_read) begin
      rd_ptr           <= rd_ptr + 1;
      pop_cnt          <= pop_cnt + 1;
      pop_cyc[pop_cnt[4:0]] <= cyc;
      if (!bus.fifo_has_data) bad_pops <= bad_pops + 1;
    end
  end

  typedef struct {
    logic [7:0]  data;
    logic [31:0] bt;
    logic        inv;
    int          bclk;
    logic [9:0]  line;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push(input logic [7:0] d);
    fmem[wr_ptr[4:0]] = d;
    wr_ptr++;
  endtask

  // Returns at the negedge right after the launch edge (frame cycle c=0).
  task automatic start_pulse(output logic rd_seen);
    @(negedge clk);
    bus.start_transmission = 1'b1;
    #1 rd_seen = bus.fifo_read;
    @(negedge clk);
    bus.start_transmission = 1'b0;
  endtask

  // Launches and checks line, in_progress and bit_tick on every clock of nbits bit periods.
  task automatic check_stream(input string name, input logic [19:0] expl, input int nbits,
                              input int b, input logic inv);
    logic rd;
    int   ticks;
    int   pops0;
    int   f;
    logic exp_tx;
    f     = nbits * b;
    ticks = 0;
    pops0 = pop_cnt;
    start_pulse(rd);
    chk({name, " fifo_read at launch"}, {31'b0, rd}, 32'd1);
    for (int c = 0; c <= f + 1; c++) begin
      if (c > 0) @(negedge clk);
      exp_tx = (c == 0 || c == f + 1) ? ~inv : expl[(c - 1) / b];
      chk($sformatf("%s tx c=%0d", name, c), {31'b0, bus.tx_line}, {31'b0, exp_tx});
      chk($sformatf("%s busy c=%0d", name, c), {31'b0, bus.transmission_in_progress},
          (c < f) ? 32'd1 : 32'd0);
      if (bus.bit_tick) ticks++;
    end
    chk({name, " bit_ticks"}, ticks, nbits);
    chk({name, " pops"}, pop_cnt - pops0, nbits / 10);
  endtask

  task automatic measure_len(input string name, input int expected);
    int len;
    len = 0;
    while (bus.transmission_in_progress && len < 1000) begin
      len++;
      @(negedge clk);
    end
    chk(name, len, expected);
  endtask

  logic rd;

  initial begin
    vecs[0] = '{data: 8'hA5, bt: 32'd4, inv: 1'b0, bclk: 4, line: 10'b1101001010};
    vecs[1] = '{data: 8'h01, bt: 32'd2, inv: 1'b1, bclk: 2, line: 10'b0111111101};
    vecs[2] = '{data: 8'h3C, bt: 32'd0, inv: 1'b0, bclk: 1, line: 10'b1001111000};
    vecs[3] = '{data: 8'h96, bt: 32'd1, inv: 1'b0, bclk: 1, line: 10'b1100101100};
    vecs[4] = '{data: 8'hC3, bt: 32'd5, inv: 1'b0, bclk: 5, line: 10'b1110000110};

    rst_n                  = 1'b0;
    bus.bit_time           = 32'd4;
    bus.start_transmission = 1'b0;
    bus.line_invert        = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset tx_line", {31'b0, bus.tx_line}, 32'd1);
    chk("reset busy", {31'b0, bus.transmission_in_progress}, 32'd0);
    chk("reset fifo_read", {31'b0, bus.fifo_read}, 32'd0);
    chk("reset bit_tick", {31'b0, bus.bit_tick}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Start with an empty FIFO must be ignored.
    start_pulse(rd);
    chk("empty fifo_read", {31'b0, rd}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("empty busy %0d", i), {31'b0, bus.transmission_in_progress}, 32'd0);
      chk($sformatf("empty tx %0d", i), {31'b0, bus.tx_line}, 32'd1);
      @(negedge clk);
    end

    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      bus.bit_time    = vecs[v].bt;
      bus.line_invert = vecs[v].inv;
      push(vecs[v].data);
      check_stream($sformatf("vec%0d", v), {10'b0, vecs[v].line}, 10, vecs[v].bclk, vecs[v].inv);
    end

    // Back-to-back 0x00 then 0xFF at 3 clocks/bit: 60 busy clocks, pops 30 apart.
    @(negedge clk);
    bus.line_invert = 1'b0;
    bus.bit_time    = 32'd3;
    push(8'h00);
    push(8'hFF);
    check_stream("b2b", {10'b1111111110, 10'b1000000000}, 20, 3, 1'b0);
    chk("b2b pop spacing", pop_cyc[(pop_cnt - 1) % 32] - pop_cyc[(pop_cnt - 2) % 32], 30);

    // Invert toggled mid-frame: 0x00 at 2 clocks/bit, c=5..7 all sit in level-0 bits.
    @(negedge clk);
    bus.bit_time = 32'd2;
    push(8'h00);
    start_pulse(rd);
    repeat (5) @(negedge clk);
    chk("inv before", {31'b0, bus.tx_line}, 32'd0);
    bus.line_invert = 1'b1;
    @(negedge clk);
    chk("inv flipped", {31'b0, bus.tx_line}, 32'd1);
    bus.line_invert = 1'b0;
    @(negedge clk);
    chk("inv restored", {31'b0, bus.tx_line}, 32'd0);
    measure_len("inv frame rest", 13);

    // bit_time 4 -> 8 three clocks into a frame: this frame stays 40 clocks, next is 80.
    @(negedge clk);
    bus.bit_time = 32'd4;
    push(8'h11);
    start_pulse(rd);
    repeat (3) @(negedge clk);
    bus.bit_time = 32'd8;
    measure_len("bt change old frame rest", 37);
    push(8'h22);
    start_pulse(rd);
    measure_len("bt change new frame", 80);

    // Reset during DATA bit 3 of 0x52 (bit3=0); 0x52 is lost, 0x33 goes next.
    @(negedge clk);
    bus.bit_time = 32'd4;
    push(8'h52);
    push(8'h33);
    start_pulse(rd);
    repeat (17) @(negedge clk);
    chk("pre-reset tx", {31'b0, bus.tx_line}, 32'd0);
    chk("pre-reset busy", {31'b0, bus.transmission_in_progress}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid reset tx", {31'b0, bus.tx_line}, 32'd1);
    chk("mid reset busy", {31'b0, bus.transmission_in_progress}, 32'd0);
    chk("mid reset fifo_read", {31'b0, bus.fifo_read}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post reset busy", {31'b0, bus.transmission_in_progress}, 32'd0);
    check_stream("after reset", {10'b0, 10'b1001100110}, 10, 4, 1'b0);

    chk("pop when empty", bad_pops, 0);
    chk("fifo drained", rd_ptr, wr_ptr);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
